// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the IF stage: FSM encoding, reset PC, NOP word and the fetch payload.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_ISSUE = 2'b00;
  localparam logic [ST_W-1:0] ST_WAIT  = 2'b01;
  localparam logic [ST_W-1:0] ST_HOLD  = 2'b10;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  // PC and instruction word handed from IF to ID
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  // Clear the byte offset so every fetch is word aligned
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(32'd3);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load on fire, bubble on flush or idle, hold on stall.
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic            i_stall,
  input  fetch_pkt_t      i_pkt,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instr,
  output logic            o_valid
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_valid;

  // Load has priority; a flush or a non-stalled idle cycle inserts a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_pkt.pc;
      r_instr <= i_pkt.instr;
      r_valid <= 1'b1;
    end else if (i_flush || !i_stall) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC register, one-outstanding imem fetch FSM and IF/ID register.
// Optional build macro IF_PERF_CNT_EN adds wait-cycle and flush counters.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] new_pc,
  input  logic            flush,
  input  logic            stall,
  output logic [XLEN-1:0] pc_if,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] instr_id,
  output logic            valid_id,
  output logic            fetch_busy
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_wait_cycles,
  output logic [31:0]     perf_flushes
`endif
);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_hold;
  logic [XLEN-1:0] w_hold_nxt;
  logic [XLEN-1:0] w_word;
  logic            r_kill;
  logic            w_kill_nxt;
  logic            w_fire;
  logic            w_flush_ok;
  fetch_pkt_t      w_pkt;

  // A flush raised under stall is not honoured
  assign w_flush_ok = flush & ~stall;

  // Fetch state, PC, kill flag and hold buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ISSUE;
      r_pc    <= word_align(RESET_PC);
      r_kill  <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Next-state decode; kill marks an in-flight response that must be dropped
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_hold_nxt  = r_hold;
    w_fire      = 1'b0;
    w_word      = r_hold;
    unique case (r_state)
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
        if (w_flush_ok) w_kill_nxt = 1'b1;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (r_kill) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = ST_ISSUE;
          end else if (w_flush_ok) begin
            w_state_nxt = ST_ISSUE;
          end else if (!stall) begin
            w_fire      = 1'b1;
            w_word      = imem_rdata;
            w_state_nxt = ST_ISSUE;
          end else begin
            w_hold_nxt  = imem_rdata;
            w_state_nxt = ST_HOLD;
          end
        end else if (w_flush_ok) begin
          w_kill_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          w_fire      = !w_flush_ok;
          w_state_nxt = ST_ISSUE;
        end
      end
      default: w_state_nxt = ST_ISSUE;
    endcase
    if (w_fire || w_flush_ok) w_pc_nxt = word_align(new_pc);
  end

  assign w_pkt = '{pc: r_pc, instr: w_word};

  // ID slot register
  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_fire),
    .i_flush (w_flush_ok),
    .i_stall (stall),
    .i_pkt   (w_pkt),
    .o_pc    (pc_id),
    .o_instr (instr_id),
    .o_valid (valid_id)
  );

  // Request is gated by reset so the bus stays idle while rst_n is low
  assign imem_req   = rst_n & (r_state == ST_ISSUE);
  assign imem_addr  = word_align(r_pc);
  assign pc_if      = r_pc;
  assign fetch_busy = (r_state == ST_WAIT) && !(imem_rvalid && !r_kill);

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_wait;
  logic [31:0] r_perf_flush;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_wait  <= '0;
      r_perf_flush <= '0;
    end else begin
      if (fetch_busy) r_perf_wait  <= r_perf_wait + 32'd1;
      if (w_flush_ok) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_wait_cycles = r_perf_wait;
  assign perf_flushes     = r_perf_flush;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: expected requests and ID deliveries are queued
// up front, monitors pop and compare, directed checks cover reset, stall, flush and reset-abort.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] new_pc;
  logic        flush;
  logic        stall;
  logic [31:0] pc_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        valid_id;
  logic        fetch_busy;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_wait_cycles;
  logic [31:0] perf_flushes;
`endif

  logic        use_tgt;
  logic [31:0] tgt;
  int          lat;
  int          n_pass;
  int          n_total;

  logic [31:0] exp_req[$];
  fetch_pkt_t  exp_id[$];

  // Next-PC logic stand-in: sequential unless a redirect target is selected
  assign new_pc = use_tgt ? tgt : pc_if + 32'd4;

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .new_pc      (new_pc),
    .flush       (flush),
    .stall       (stall),
    .pc_if       (pc_if),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_id       (pc_id),
    .instr_id    (instr_id),
    .valid_id    (valid_id),
    .fetch_busy  (fetch_busy)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_wait_cycles (perf_wait_cycles),
    .perf_flushes     (perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2402_0001;
    return {16'hDEAD, a[15:0]};
  endfunction

  // Stimulus points sit 3 time units after each falling edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #3;
    end
  endtask

  // Instruction memory: samples the request just before the edge, answers after lat cycles;
  // a request outstanding across reset is answered once as a stale word
  initial begin : imem_model
    logic        req_s;
    logic        rst_s;
    logic [31:0] addr_s;
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend  = 1'b0;
    paddr = '0;
    cnt   = 0;
    forever begin
      @(negedge clk);
      #4;
      req_s  = imem_req;
      rst_s  = rst_n;
      addr_s = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (!rst_s) begin
        if (pend) begin
          imem_rvalid = 1'b1;
          imem_rdata  = 32'hBAD0_BAD0;
        end
        pend = 1'b0;
      end else begin
        if (req_s) begin
          pend  = 1'b1;
          paddr = addr_s;
          cnt   = lat;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(paddr);
            pend        = 1'b0;
          end
        end
      end
    end
  end

  // Request monitor: every issued fetch address against the expected sequence
  initial begin : mon_req
    forever begin
      @(negedge clk);
      #4;
      if (imem_req === 1'b1) begin
        if (exp_req.size() == 0) begin
          n_total++;
          $display("FAIL req_unexpected: addr %h with no request expected", imem_addr);
        end else begin
          chk("req_addr", imem_addr, exp_req.pop_front());
        end
      end
    end
  end

  // ID monitor: a valid slot not held over by stall is a new delivery
  initial begin : mon_id
    logic       prev_valid;
    fetch_pkt_t pkt;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (valid_id === 1'b1 && !(prev_valid && stall)) begin
        if (exp_id.size() == 0) begin
          n_total++;
          $display("FAIL id_unexpected: pc %h instr %h with no delivery expected", pc_id, instr_id);
        end else begin
          pkt = exp_id.pop_front();
          chk("id_pc", pc_id, pkt.pc);
          chk("id_instr", instr_id, pkt.instr);
        end
      end
      prev_valid = (valid_id === 1'b1);
    end
  end

  initial begin : stim
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    use_tgt = 1'b0;
    tgt     = '0;
    lat     = 1;

    exp_req = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3040, 32'h3044,
                32'h3040, 32'h3044, 32'h3048, 32'h3000, 32'h3004};
    exp_id.push_back('{pc: 32'h3000, instr: 32'h2402_0001});
    exp_id.push_back('{pc: 32'h3004, instr: 32'hDEAD_3004});
    exp_id.push_back('{pc: 32'h3008, instr: 32'hDEAD_3008});
    exp_id.push_back('{pc: 32'h3040, instr: 32'hDEAD_3040});
    exp_id.push_back('{pc: 32'h3040, instr: 32'hDEAD_3040});
    exp_id.push_back('{pc: 32'h3044, instr: 32'hDEAD_3044});
    exp_id.push_back('{pc: 32'h3000, instr: 32'h2402_0001});

    cyc(2);
    chk("rst_pc_if", pc_if, 32'h3000);
    chk("rst_pc_id", pc_id, 32'h0);
    chk("rst_instr_id", instr_id, 32'h0);
    chk("rst_valid_id", 32'(valid_id), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_fetch_busy", 32'(fetch_busy), 32'd0);
    rst_n = 1'b1;

    cyc(1);
    chk("wait_resp_busy", 32'(fetch_busy), 32'd0);
    chk("wait_no_req", 32'(imem_req), 32'd0);
    cyc(1);
    chk("first_pc_if", pc_if, 32'h3004);
    chk("first_valid_id", 32'(valid_id), 32'd1);

    // Stall spans the response: word parks in the hold buffer
    cyc(2);
    stall = 1'b1;
    cyc(2);
    chk("hold_pc_if", pc_if, 32'h3008);
    chk("hold_pc_id", pc_id, 32'h3004);
    chk("hold_valid_id", 32'(valid_id), 32'd1);
    chk("hold_busy", 32'(fetch_busy), 32'd0);
    chk("hold_no_req", 32'(imem_req), 32'd0);
    cyc(1);
    stall = 1'b0;
    cyc(1);
    chk("unhold_instr_id", instr_id, 32'hDEAD_3008);
    chk("unhold_pc_if", pc_if, 32'h300C);
    lat = 3;

    // Flush while waiting on a slow response
    cyc(1);
    flush   = 1'b1;
    use_tgt = 1'b1;
    tgt     = 32'h3040;
    cyc(1);
    flush   = 1'b0;
    use_tgt = 1'b0;
    lat     = 1;
    chk("flush_wait_pc_if", pc_if, 32'h3040);
    chk("flush_wait_valid", 32'(valid_id), 32'd0);
    chk("flush_wait_busy", 32'(fetch_busy), 32'd1);
    chk("flush_wait_no_req", 32'(imem_req), 32'd0);
    cyc(2);
    chk("killed_valid", 32'(valid_id), 32'd0);
    chk("killed_req", 32'(imem_req), 32'd1);
    chk("killed_addr", imem_addr, 32'h3040);

    // Flush coincident with the response
    cyc(3);
    chk("coinc_busy", 32'(fetch_busy), 32'd0);
    flush   = 1'b1;
    use_tgt = 1'b1;
    tgt     = 32'h3040;
    cyc(1);
    flush   = 1'b0;
    use_tgt = 1'b0;
    chk("coinc_pc_if", pc_if, 32'h3040);
    chk("coinc_req", 32'(imem_req), 32'd1);
    chk("coinc_addr", imem_addr, 32'h3040);
    chk("coinc_valid", 32'(valid_id), 32'd0);

    // Stall and flush together: flush must be ignored
    cyc(2);
    chk("refetch_instr", instr_id, 32'hDEAD_3040);
    chk("refetch_pc_if", pc_if, 32'h3044);
    stall   = 1'b1;
    flush   = 1'b1;
    use_tgt = 1'b1;
    tgt     = 32'h3080;
    cyc(2);
    chk("sf_pc_if", pc_if, 32'h3044);
    chk("sf_pc_id", pc_id, 32'h3040);
    chk("sf_valid", 32'(valid_id), 32'd1);
    stall   = 1'b0;
    flush   = 1'b0;
    use_tgt = 1'b0;
    cyc(1);
    chk("sf_release_instr", instr_id, 32'hDEAD_3044);
    lat = 3;

    // Reset during WAIT with a response still outstanding
    cyc(1);
    rst_n = 1'b0;
    lat   = 1;
    cyc(1);
    chk("rst2_pc_if", pc_if, 32'h3000);
    chk("rst2_pc_id", pc_id, 32'h0);
    chk("rst2_instr_id", instr_id, 32'h0);
    chk("rst2_valid", 32'(valid_id), 32'd0);
    chk("rst2_req", 32'(imem_req), 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("rst2_perf_wait", perf_wait_cycles, 32'd0);
    chk("rst2_perf_flush", perf_flushes, 32'd0);
`endif
    rst_n = 1'b1;
    cyc(2);
    chk("rst2_fetch_pc_id", pc_id, 32'h3000);
    chk("rst2_fetch_instr", instr_id, 32'h2402_0001);
    chk("rst2_fetch_valid", 32'(valid_id), 32'd1);

    cyc(1);
    chk("req_queue_left", 32'(exp_req.size()), 32'd0);
    chk("id_queue_left", 32'(exp_id.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
PC register plus fetch FSM plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Holds the current fetch PC and drives it to the next-PC logic.
- Issues word fetches to instruction memory over a one-outstanding request/response handshake.
- Delivers {pc, instr, valid} to the ID stage.
- Loads the redirect/next address from the next-PC logic on instruction acceptance or on flush.
- Honours the pipeline stall and flush controls.

Parameters:
RESET_PC, 32'h0000_3000, fetch address after reset.
NOP_INSTR, 32'h0000_0000, instruction word injected into ID on bubble or flush.

Ports:
clk  in  1  pipeline clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
new_pc  in  32  next fetch address from the next-PC logic.
flush  in  1  redirect taken in ID; squash the in-flight fetch and the ID slot.
stall  in  1  combined hazard stall (load-use/branch); freezes the ID register.
pc_if  out  32  current fetch PC, fed to the next-PC logic as its old PC.
imem_req  out  1  one-cycle request pulse.
imem_addr  out  32  word address: {pc_if[31:2],2'b00}.
imem_rvalid  in  1  response valid, at least 1 cycle after imem_req.
imem_rdata  in  32  instruction word, valid with imem_rvalid.
pc_id  out  32  PC of the instruction in ID.
instr_id  out  32  instruction in ID.
valid_id  out  1  ID slot holds a real instruction.
fetch_busy  out  1  high while WAIT and no usable response this cycle.

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is asynchronous, active-low (rst_n).
- Reset values:
  - pc_if=RESET_PC, state=ISSUE, kill=0, hold buffer=0.
  - pc_id=0, instr_id=NOP_INSTR, valid_id=0, imem_req=0.
  - First request is issued in the first cycle after rst_n deasserts.
- Priority:
  - stall beats flush. Flush is ignored while stall=1, matching the next-PC logic, which never raises flush while stalled.
- "fire": the fetched word is accepted into ID. On fire:
  - pc_id<=pc_if, instr_id<=word, valid_id<=1.
  - pc_if<=new_pc with bits[1:0] forced to 0.
  - Next state is ISSUE.
- On flush (stall=0):
  - ID gets a bubble: valid_id<=0, instr_id<=NOP_INSTR.
  - pc_if<=new_pc (aligned).
  - Any buffered or in-flight word is discarded.
- ID register when neither fire nor flush:
  - If stall=1, the ID register holds.
  - Otherwise the ID register loads a bubble (valid_id<=0).
- FSM states:
  - ISSUE:
    - imem_req=1, addr from pc_if; next state WAIT.
    - If flush this cycle: pc_if<=new_pc, kill<=1.
  - WAIT:
    - rvalid with kill=1: drop the word, kill<=0, go to ISSUE.
    - rvalid with kill=0 and flush: drop the word, redirect, go to ISSUE.
    - rvalid with kill=0, no flush, stall=0: fire with imem_rdata.
    - rvalid with kill=0, stall=1: capture the word into the hold buffer, go to HOLD.
    - No rvalid and flush: redirect, kill<=1, stay in WAIT.
  - HOLD:
    - stall=1: stay.
    - stall=0 and flush: discard the buffer, redirect, go to ISSUE.
    - stall=0 otherwise: fire from the buffer.
- imem_rvalid outside WAIT is ignored. This covers a stale response from a request made before reset.
- Throughput: at most one instruction per 2 cycles (ISSUE then WAIT with 1-cycle memory latency).
- fetch_busy is combinational: (state==WAIT) && !(imem_rvalid && !kill).

Optional Feature:
IF_PERF_CNT_EN.
- Defined: adds outputs perf_wait_cycles[31:0] and perf_flushes[31:0].
  - Counters reset to 0 on rst_n.
  - perf_wait_cycles increments every cycle fetch_busy=1.
  - perf_flushes increments on every honoured flush (stall=0).
  - Both wrap at 2^32.
- Undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package holds the FSM state encoding (ISSUE=2'b00, WAIT=2'b01, HOLD=2'b10), RESET_PC default and the NOP encoding.
- One natural sub-module: if_id_reg (ID pipeline register with stall-hold, flush-bubble and load inputs).

Test Plan:
- Reset release, memory with 1-cycle latency returning 0x2402_0001 → imem_addr=0x3000 in cycle 1; pc_id=0x3000, instr_id=0x2402_0001, valid_id=1 two cycles later; pc_if=0x3004 (new_pc=pc+4).
- stall=1 for 3 cycles while rvalid arrives → state HOLD, ID unchanged, pc_if unchanged; stall drops → buffered word enters ID next edge.
- flush with new_pc=0x3040 during WAIT, response arrives 2 cycles later → word dropped, valid_id=0, next imem_addr=0x3040.
- flush and rvalid same cycle → word dropped, pc_if=0x3040, request to 0x3040 next cycle, no kill left pending.
- stall and flush both high → flush ignored, pc_if and ID hold.
- rst_n pulsed low mid-WAIT, then a stale rvalid arrives → outputs at reset values, stale word ignored, fresh fetch at 0x3000. With IF_PERF_CNT_EN defined, counters read 0.
